// File: rtl/stopwatch_counter.sv
// BCD MM:SS.t stopwatch core driven by the 10 Hz tick.
// Run/pause/clear control plus manual adjust of seconds or minutes.
module stopwatch_counter #(
  parameter int MAX_MIN_TENS = 5,
  parameter int TENTHS_MAX   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_10hz,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adj,
  input  logic       adj_sel,
  input  logic       adj_tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);
  localparam logic [3:0] TE_MAX = 4'(TENTHS_MAX);

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    PAUSED,
    ADJUST
  } state_t;

  state_t state, next_state;

  logic [3:0] n_mt, n_mo, n_st, n_so, n_te;
  logic       n_wrap;
  logic       count_en, adj_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= STOPPED;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear_pulse) begin
      next_state = adj ? ADJUST : STOPPED;
    end else if (adj) begin
      next_state = ADJUST;
    end else if (state == ADJUST) begin
      next_state = PAUSED;
    end else if (pause_pulse) begin
      next_state = (state == RUNNING) ? PAUSED : RUNNING;
    end
  end

  always_comb begin
    running = (state == RUNNING);
  end

  assign count_en = (state == RUNNING) && tick_10hz;
  assign adj_en   = (state == ADJUST) && adj_tick;

  // Running count ripples through every digit; adjust wraps one field only.
  always_comb begin
    n_mt   = min_tens;
    n_mo   = min_ones;
    n_st   = sec_tens;
    n_so   = sec_ones;
    n_te   = tenths;
    n_wrap = 1'b0;
    if (clear_pulse) begin
      n_mt = '0;
      n_mo = '0;
      n_st = '0;
      n_so = '0;
      n_te = '0;
    end else if (count_en) begin
      if (tenths != TE_MAX) begin
        n_te = tenths + 4'd1;
      end else begin
        n_te = '0;
        if (sec_ones != 4'd9) begin
          n_so = sec_ones + 4'd1;
        end else begin
          n_so = '0;
          if (sec_tens != 4'd5) begin
            n_st = sec_tens + 4'd1;
          end else begin
            n_st = '0;
            if (min_ones != 4'd9) begin
              n_mo = min_ones + 4'd1;
            end else begin
              n_mo = '0;
              if (min_tens != MT_MAX) begin
                n_mt = min_tens + 4'd1;
              end else begin
                n_mt   = '0;
                n_wrap = 1'b1;
              end
            end
          end
        end
      end
    end else if (adj_en) begin
      n_te = '0;
      if (adj_sel) begin
        if (min_ones != 4'd9) begin
          n_mo = min_ones + 4'd1;
        end else begin
          n_mo = '0;
          n_mt = (min_tens == MT_MAX) ? 4'd0 : min_tens + 4'd1;
        end
      end else begin
        if (sec_ones != 4'd9) begin
          n_so = sec_ones + 4'd1;
        end else begin
          n_so = '0;
          n_st = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      tenths   <= '0;
      wrap     <= 1'b0;
    end else begin
      min_tens <= n_mt;
      min_ones <= n_mo;
      sec_tens <= n_st;
      sec_ones <= n_so;
      tenths   <= n_te;
      wrap     <= n_wrap;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter.
// Reference model keeps the count as total tenths of a second.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_10hz = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       clear_pulse = 1'b0;
  logic       adj = 1'b0;
  logic       adj_sel = 1'b0;
  logic       adj_tick = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, tenths;
  logic       running, wrap;

  stopwatch_counter dut (
    .clk         (clk),
    .reset       (reset),
    .tick_10hz   (tick_10hz),
    .pause_pulse (pause_pulse),
    .clear_pulse (clear_pulse),
    .adj         (adj),
    .adj_sel     (adj_sel),
    .adj_tick    (adj_tick),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .tenths      (tenths),
    .running     (running),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] digits;
    logic        run;
    logic        wrp;
  } exp_t;

  localparam int ST_STOP  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_ADJ   = 3;
  localparam int SPAN     = 36000;

  exp_t q[$];
  int   m_st  = ST_STOP;
  int   m_cnt = 0;
  logic adj_lvl = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int c);
    int m, s, t;
    m = c / 600;
    s = (c / 10) % 60;
    t = c % 10;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t)};
  endfunction

  function automatic logic [19:0] dut_digits();
    return {min_tens, min_ones, sec_tens, sec_ones, tenths};
  endfunction

  task automatic step(input logic tk, input logic pp, input logic cp,
                      input logic a, input logic sel, input logic at);
    exp_t e;
    int   ncnt, nst, m, s;
    logic nw;
    tick_10hz   = tk;
    pause_pulse = pp;
    clear_pulse = cp;
    adj         = a;
    adj_sel     = sel;
    adj_tick    = at;
    adj_lvl     = a;
    ncnt = m_cnt;
    nw   = 1'b0;
    if (cp) begin
      ncnt = 0;
    end else if (m_st == ST_RUN && tk) begin
      ncnt = (m_cnt + 1) % SPAN;
      nw   = (ncnt == 0);
    end else if (m_st == ST_ADJ && at) begin
      m = m_cnt / 600;
      s = (m_cnt / 10) % 60;
      if (sel) m = (m + 1) % 60;
      else     s = (s + 1) % 60;
      ncnt = m * 600 + s * 10;
    end
    if (cp)                  nst = a ? ST_ADJ : ST_STOP;
    else if (a)              nst = ST_ADJ;
    else if (m_st == ST_ADJ) nst = ST_PAUSE;
    else if (pp)             nst = (m_st == ST_RUN) ? ST_PAUSE : ST_RUN;
    else                     nst = m_st;
    m_cnt = ncnt;
    m_st  = nst;
    e.digits = to_bcd(ncnt);
    e.run    = (nst == ST_RUN);
    e.wrp    = nw;
    q.push_back(e);
    @(posedge clk);
    #1;
    tick_10hz   = 1'b0;
    pause_pulse = 1'b0;
    clear_pulse = 1'b0;
    adj_tick    = 1'b0;
    if (q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check("digits", 32'(dut_digits()), 32'(e.digits));
      check("running", 32'(running), 32'(e.run));
      check("wrap", 32'(wrap), 32'(e.wrp));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, adj_lvl, adj_sel, 1'b0);
      step(1'b0, 1'b0, 1'b0, adj_lvl, adj_sel, 1'b0);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, adj_lvl, adj_sel, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_digits", 32'(dut_digits()), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(25);
    check("run_025", 32'(dut_digits()), 32'h00025);

    ticks(574);
    check("run_599", 32'(dut_digits()), 32'h00599);
    ticks(1);
    check("carry_min", 32'(dut_digits()), 32'h01000);
    ticks(1);
    check("after_carry", 32'(dut_digits()), 32'h01001);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_adj", 32'(dut_digits()), 32'h00000);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("adj_5959", 32'(dut_digits()), 32'h59590);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(9);
    check("pre_wrap", 32'(dut_digits()), 32'h59599);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_hi", 32'(wrap), 32'd1);
    check("wrap_zero", 32'(dut_digits()), 32'h00000);
    idle();
    check("wrap_once", 32'(wrap), 32'd0);
    check("wrap_run", 32'(running), 32'd1);

    ticks(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tp_run", 32'(dut_digits()), 32'h00004);
    check("tp_paused", 32'(running), 32'd0);
    ticks(5);
    check("paused_hold", 32'(dut_digits()), 32'h00004);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tp_resume", 32'(dut_digits()), 32'h00004);
    check("tp_running", 32'(running), 32'd1);

    ticks(583);
    check("at_587", 32'(dut_digits()), 32'h00587);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("adj_sec_wrap", 32'(dut_digits()), 32'h00010);
    ticks(2);
    check("adj_no_count", 32'(dut_digits()), 32'h00010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    check("adj_to_pause", 32'(dut_digits()), 32'h00010);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1966);
    check("at_3176", 32'(dut_digits()), 32'h03176);
    #2;
    reset = 1'b0;
    #1;
    check("async_digits", 32'(dut_digits()), 32'd0);
    check("async_running", 32'(running), 32'd0);
    m_st  = ST_STOP;
    m_cnt = 0;
    #3;
    reset = 1'b1;
    ticks(4);
    check("stopped_hold", 32'(dut_digits()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
